// File: rtl/eth_unpacker_pkg.sv
// eth_pkg: shared state type and protocol constants for the RMII receive deframer.
// CRC constants describe the reflected Ethernet CRC-32 used when ETH_UNPACKER_FCS_EN is defined.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    localparam logic [1:0]  PRE_DIBIT   = 2'b01;
    localparam logic [1:0]  SFD_DIBIT   = 2'b11;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_unpacker_if.sv
// eth_unpacker_if: RMII receive pins plus the byte stream with its frame markers.
// The deframer is the master of the byte stream; the consumer side takes the slave modport.
interface eth_unpacker_if;

    logic       phy_crsdv;
    logic [1:0] phy_rxd;
    logic       axiov;
    logic [7:0] axiod;
    logic       sof;
    logic       eof;
    logic       frame_err;
    logic       fcs_ok;

    modport master (
        input  phy_crsdv, phy_rxd,
        output axiov, axiod, sof, eof, frame_err, fcs_ok
    );

    modport slave (
        output phy_crsdv, phy_rxd,
        input  axiov, axiod, sof, eof, frame_err, fcs_ok
    );

endinterface

// File: rtl/eth_unpacker_crc32_dibit.sv
// eth_crc32_dibit: one combinational reflected CRC-32 step over a dibit, rxd[0] first.
// Only instantiated when ETH_UNPACKER_FCS_EN is defined.
module eth_crc32_dibit
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 2; i++) begin
            if (crc_out[0] ^ dibit[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_unpacker.sv
// eth_unpacker: RMII receive deframer turning the 50 MHz dibit stream into bytes with sof/eof markers.
// Define ETH_UNPACKER_FCS_EN to add CRC-32 checking that drives fcs_ok at a clean frame end.
module eth_unpacker
    import eth_pkg::*;
#(
    parameter int MAX_BYTES = 1522,
    parameter int MIN_PRE   = 4
) (
    input  logic           clk,
    input  logic           rst,
    eth_unpacker_if.master bus
);

    localparam logic [10:0] MAX_BYTES_C = 11'(MAX_BYTES);
    localparam logic [4:0]  MIN_PRE_C   = 5'(MIN_PRE);

    rx_state_t   state_q, state_d;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]  dibit_idx_q, dibit_idx_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [5:0]  shift_q, shift_d;
    logic [7:0]  axiod_q, axiod_d;
    logic        axiov_q, axiov_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        frame_err_q, frame_err_d;
    logic        fcs_ok_q, fcs_ok_d;
    logic        sfd_take, data_take, crc_good;

    assign sfd_take  = (state_q == ST_PRE) && bus.phy_crsdv &&
                       (bus.phy_rxd == SFD_DIBIT) && (pre_cnt_q >= MIN_PRE_C);
    assign data_take = (state_q == ST_DATA) && bus.phy_crsdv && (byte_cnt_q != MAX_BYTES_C);

`ifdef ETH_UNPACKER_FCS_EN
    logic [31:0] crc_q, crc_d, crc_next;

    eth_crc32_dibit u_crc (
        .crc_in  (crc_q),
        .dibit   (bus.phy_rxd),
        .crc_out (crc_next)
    );

    always_comb begin
        crc_d = crc_q;
        if (sfd_take) begin
            crc_d = CRC_INIT;
        end else if (data_take) begin
            crc_d = crc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_good = (crc_q == CRC_RESIDUE);
`else
    assign crc_good = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        dibit_idx_d = dibit_idx_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        axiod_d     = axiod_q;
        axiov_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        frame_err_d = 1'b0;
        fcs_ok_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.phy_crsdv && (bus.phy_rxd == PRE_DIBIT)) begin
                    state_d   = ST_PRE;
                    pre_cnt_d = 5'd1;
                end
            end
            ST_PRE: begin
                if (bus.phy_crsdv && (bus.phy_rxd == PRE_DIBIT)) begin
                    if (pre_cnt_q != 5'd31) begin
                        pre_cnt_d = pre_cnt_q + 5'd1;
                    end
                end else if (sfd_take) begin
                    state_d     = ST_DATA;
                    dibit_idx_d = 2'd0;
                    byte_cnt_d  = 11'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                // Carrier loss wins over overflow so a frame of exactly MAX_BYTES ends cleanly.
                if (!bus.phy_crsdv) begin
                    state_d     = ST_IDLE;
                    eof_d       = 1'b1;
                    frame_err_d = (dibit_idx_q != 2'd0);
                    fcs_ok_d    = (dibit_idx_q == 2'd0) && crc_good;
                end else if (!data_take) begin
                    state_d = ST_DROP;
                end else begin
                    dibit_idx_d = dibit_idx_q + 2'd1;
                    case (dibit_idx_q)
                        2'd0:    shift_d[1:0] = bus.phy_rxd;
                        2'd1:    shift_d[3:2] = bus.phy_rxd;
                        2'd2:    shift_d[5:4] = bus.phy_rxd;
                        default: begin
                            axiod_d    = {bus.phy_rxd, shift_q};
                            axiov_d    = 1'b1;
                            sof_d      = (byte_cnt_q == 11'd0);
                            byte_cnt_d = byte_cnt_q + 11'd1;
                        end
                    endcase
                end
            end
            ST_DROP: begin
                if (!bus.phy_crsdv) begin
                    state_d     = ST_IDLE;
                    eof_d       = 1'b1;
                    frame_err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pre_cnt_q   <= 5'd0;
            dibit_idx_q <= 2'd0;
            byte_cnt_q  <= 11'd0;
            shift_q     <= 6'd0;
            axiod_q     <= 8'd0;
            axiov_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_err_q <= 1'b0;
            fcs_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            dibit_idx_q <= dibit_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            axiod_q     <= axiod_d;
            axiov_q     <= axiov_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            frame_err_q <= frame_err_d;
            fcs_ok_q    <= fcs_ok_d;
        end
    end

    assign bus.axiov     = axiov_q;
    assign bus.axiod     = axiod_q;
    assign bus.sof       = sof_q;
    assign bus.eof       = eof_q;
    assign bus.frame_err = frame_err_q;
    assign bus.fcs_ok    = fcs_ok_q;

endmodule

// File: tb/tb_eth_unpacker.sv
// tb_eth_unpacker: drives one RMII stream into a full-size and a 16-byte-limit deframer and
// compares their byte/eof events against expectations derived from the frame contents.
module tb_eth_unpacker;

    localparam int MAX_A   = 1522;
    localparam int MAX_B   = 16;
    localparam int MIN_PRE = 4;
`ifdef ETH_UNPACKER_FCS_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    typedef struct packed {
        int         inst;
        int         cyc;
        logic       is_eof;
        logic [7:0] data;
        logic       sof;
        logic       err;
        logic       fok;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       crsdv = 1'b0;
    logic [1:0] rxd = 2'b00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    ev_t        evq[$];
    logic [2:0] stim[$];
    int         samp[$];
    logic [7:0] fbytes[$];
    int         data_start;
    int         n_data;

    eth_unpacker_if bus_a ();
    eth_unpacker_if bus_b ();

    assign bus_a.phy_crsdv = crsdv;
    assign bus_a.phy_rxd   = rxd;
    assign bus_b.phy_crsdv = crsdv;
    assign bus_b.phy_rxd   = rxd;

    eth_unpacker #(.MAX_BYTES(MAX_A), .MIN_PRE(MIN_PRE)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    eth_unpacker #(.MAX_BYTES(MAX_B), .MIN_PRE(MIN_PRE)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tg(input string name, input int inst);
        return $sformatf("%s_%0d", name, inst);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ethernet FCS of the first n frame bytes, in transmit order (byte 0 of the result goes first).
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, fbytes[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic bit fcs_valid(input int n);
        if (n < 4) return 1'b0;
        return fcs_of(n - 4) == {fbytes[n-1], fbytes[n-2], fbytes[n-3], fbytes[n-4]};
    endfunction

    task automatic sample_bus(input int inst, input logic v, input logic [7:0] d, input logic s,
                              input logic e, input logic fe, input logic fo);
        ev_t ev;
        if (!rst) check_output(tg("reset_outputs", inst), {20'd0, v, d, s, e, fe, fo}, 32'd0);
        check_output(tg("axiov_eof_exclusive", inst), 32'(v & e), 32'd0);
        check_output(tg("sof_without_axiov", inst), 32'(s & ~v), 32'd0);
        if (!e) check_output(tg("qualifiers_outside_eof", inst), 32'({fe, fo}), 32'd0);
        if (v || e) begin
            ev.inst   = inst;
            ev.cyc    = cyc;
            ev.is_eof = e;
            ev.data   = d;
            ev.sof    = s;
            ev.err    = fe;
            ev.fok    = fo;
            evq.push_back(ev);
        end
    endtask

    always @(negedge clk) begin
        sample_bus(0, bus_a.axiov, bus_a.axiod, bus_a.sof, bus_a.eof, bus_a.frame_err, bus_a.fcs_ok);
        sample_bus(1, bus_b.axiov, bus_b.axiod, bus_b.sof, bus_b.eof, bus_b.frame_err, bus_b.fcs_ok);
    end

    task automatic drive_dibit(input logic c, input logic [1:0] d);
        @(negedge clk);
        crsdv = c;
        rxd   = d;
        samp.push_back(cyc + 1);
    endtask

    // Preamble of npre 01 dibits, SFD, fbytes LSB-first, extra partial dibits, then carrier drop.
    task automatic build_frame(input int npre, input bit with_fcs, input int flip, input int extra);
        logic [31:0] f;
        logic [7:0]  t;
        stim.delete();
        if (with_fcs) begin
            f = fcs_of(fbytes.size());
            for (int i = 0; i < 4; i++) fbytes.push_back(f[8*i +: 8]);
        end
        if (flip >= 0) begin
            t = fbytes[flip / 8];
            t[flip % 8] = ~t[flip % 8];
            fbytes[flip / 8] = t;
        end
        for (int i = 0; i < npre; i++) stim.push_back({1'b1, 2'b01});
        stim.push_back({1'b1, 2'b11});
        data_start = stim.size();
        foreach (fbytes[i]) begin
            t = fbytes[i];
            for (int j = 0; j < 4; j++) stim.push_back({1'b1, t[2*j +: 2]});
        end
        for (int i = 0; i < extra; i++) stim.push_back({1'b1, 2'($urandom_range(0, 3))});
        n_data = stim.size() - data_start;
        stim.push_back(3'b000);
    endtask

    task automatic apply_stimulus();
        logic [2:0] s;
        evq.delete();
        samp.delete();
        foreach (stim[i]) begin
            s = stim[i];
            drive_dibit(s[2], s[1:0]);
        end
        repeat (6) drive_dibit(1'b0, 2'b00);
    endtask

    task automatic check_frame(input int inst, input int maxb);
        ev_t got[$];
        int  nb;
        bit  err;
        bit  fok;
        foreach (evq[i]) if (evq[i].inst == inst) got.push_back(evq[i]);
        nb  = (n_data / 4 > maxb) ? maxb : n_data / 4;
        err = (n_data % 4 != 0) || (n_data > 4 * maxb);
        fok = FCS_EN && !err && fcs_valid(n_data / 4);
        check_output(tg("event_count", inst), 32'(got.size()), 32'(nb + 1));
        foreach (got[i]) begin
            if (i < nb) begin
                check_output(tg("byte_not_eof", inst), 32'(got[i].is_eof), 32'd0);
                check_output(tg("byte_data", inst), 32'(got[i].data), 32'(fbytes[i]));
                check_output(tg("byte_sof", inst), 32'(got[i].sof), 32'(i == 0));
                check_output(tg("byte_cycle", inst), 32'(got[i].cyc), 32'(samp[data_start + 4*i + 3]));
            end else if (i == nb) begin
                check_output(tg("eof_flag", inst), 32'(got[i].is_eof), 32'd1);
                check_output(tg("eof_frame_err", inst), 32'(got[i].err), 32'(err));
                check_output(tg("eof_fcs_ok", inst), 32'(got[i].fok), 32'(fok));
                check_output(tg("eof_cycle", inst), 32'(got[i].cyc), 32'(samp[data_start + n_data]));
            end
        end
    endtask

    task automatic run_frame(input int npre, input bit with_fcs, input int flip, input int extra);
        build_frame(npre, with_fcs, flip, extra);
        apply_stimulus();
        check_frame(0, MAX_A);
        check_frame(1, MAX_B);
    endtask

    task automatic fill_random(input int n);
        fbytes.delete();
        for (int i = 0; i < n; i++) fbytes.push_back(8'($urandom));
    endtask

    initial begin
        int r;

        $display("[TB] reset held with random line activity");
        #2 rst = 1'b0;
        repeat (20) drive_dibit(1'($urandom), 2'($urandom));
        check_output("events_in_reset", 32'(evq.size()), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        evq.delete();
        repeat (20) begin
            r = $urandom_range(0, 2);
            drive_dibit(1'($urandom), (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11));
        end
        repeat (4) drive_dibit(1'b0, 2'b00);
        check_output("events_without_preamble", 32'(evq.size()), 32'd0);

        $display("[TB] basic frame 0x12 0x34");
        fbytes = '{8'h12, 8'h34};
        run_frame(31, 1'b0, -1, 0);

        $display("[TB] short preambles");
        fbytes = '{8'hFF, 8'hFF};
        build_frame(2, 1'b0, -1, 0);
        apply_stimulus();
        check_output("events_pre2", 32'(evq.size()), 32'd0);
        build_frame(3, 1'b0, -1, 0);
        apply_stimulus();
        check_output("events_pre3", 32'(evq.size()), 32'd0);
        fbytes = '{8'hA5, 8'h3C, 8'h01};
        run_frame(MIN_PRE, 1'b0, -1, 0);

        $display("[TB] truncation and zero-byte frame");
        fill_random(2);
        run_frame(12, 1'b0, -1, 2);
        fbytes.delete();
        run_frame(8, 1'b0, -1, 0);

        $display("[TB] overflow limits");
        fill_random(20);
        run_frame(31, 1'b0, -1, 0);
        fill_random(16);
        run_frame(31, 1'b0, -1, 0);

        $display("[TB] fcs good and corrupted");
        fill_random(60);
        run_frame(31, 1'b1, -1, 0);
        fill_random(60);
        run_frame(31, 1'b1, 8*10 + 3, 0);

        $display("[TB] reset in mid-frame");
        fill_random(6);
        build_frame(10, 1'b0, -1, 0);
        evq.delete();
        for (int i = 0; i < data_start + 9; i++) drive_dibit(stim[i][2], stim[i][1:0]);
        #2 rst = 1'b0;
        repeat (3) drive_dibit(1'b1, 2'b10);
        check_output("bytes_before_reset", 32'(evq.size()), 32'd4);
        #2 rst = 1'b1;
        evq.delete();
        repeat (4) begin
            drive_dibit(1'b1, 2'b11);
            drive_dibit(1'b1, 2'b11);
            drive_dibit(1'b1, 2'b00);
            drive_dibit(1'b1, 2'b00);
        end
        repeat (4) drive_dibit(1'b0, 2'b00);
        check_output("events_after_reset", 32'(evq.size()), 32'd0);

        $display("[TB] randomized frames");
        for (int k = 0; k < 25; k++) begin
            fill_random($urandom_range(0, 24));
            run_frame($urandom_range(MIN_PRE, 40), 1'($urandom), -1,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
